// File: rtl/play_judge.sv
// play_judge: note-judging and scoring engine for STUDY / CHALLENGE play.
// Judges each expected note against the pressed keys on divided ticks.
// Keeps per-run hit and mistake counts, and saturating per-account scores.
//
// state | meaning
// IDLE  | waiting for start; counters hold the last run's values
// RUN   | judging notes on each tick until song_end or abort
// SCORE | one cycle: award tier points to the latched account, pulse done
module play_judge #(
  parameter int KEYS       = 8,
  parameter int ACCOUNTS   = 8,
  parameter int SCORE_W    = 10,
  parameter int CNT_W      = 8,
  parameter int TICK_DIV   = 524288,
  parameter int WIN_EASY   = 60,
  parameter int WIN_NORMAL = 45,
  parameter int WIN_HARD   = 30,
  parameter int WIN_STUDY  = 120,
  parameter int T1         = 10,
  parameter int T2         = 20,
  parameter int T3         = 30,
  parameter int T4         = 40,
  parameter int P1         = 5,
  parameter int P2         = 3,
  parameter int P3         = 2,
  parameter int P4         = 1,
  localparam int AW        = (ACCOUNTS > 1) ? $clog2(ACCOUNTS) : 1,
  localparam int DW        = $clog2(TICK_DIV)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic               study_i,
  input  logic [1:0]         difficulty_i,
  input  logic [AW-1:0]      account_i,
  input  logic               abort_i,
  input  logic [KEYS-1:0]    key_i,
  input  logic [KEYS-1:0]    reminder_i,
  input  logic               song_end_i,
  output logic               busy_o,
  output logic [CNT_W-1:0]   mistakes_o,
  output logic [CNT_W-1:0]   hits_o,
  output logic [SCORE_W-1:0] score_o,
  output logic               done_o
);

  typedef enum logic [1:0] {IDLE, RUN, SCORE} state_t;

  state_t             state_q, state_d;
  logic [DW-1:0]      div_q, div_d;
  logic               tick;
  logic [CNT_W-1:0]   mist_q, mist_d, hits_q, hits_d;
  logic [7:0]         w_q, w_d, win_q, win_d, win_sel;
  logic               judged_q, judged_d, study_q, study_d, done_q, done_d;
  logic [AW-1:0]      acct_q, acct_d;
  logic [KEYS-1:0]    last_q, last_d;
  logic [SCORE_W-1:0] score_q [ACCOUNTS];
  logic [SCORE_W-1:0] score_cur, score_new;
  logic [31:0]        award;
  logic [32:0]        sum;

  // free-running tick divider; tick marks the last clk of each period
  assign tick  = (div_q == DW'(TICK_DIV - 1));
  assign div_d = tick ? '0 : div_q + DW'(1);

  // reaction window chosen from the mode inputs at start
  always_comb begin
    win_sel = 8'(WIN_EASY);
    if (study_i)                   win_sel = 8'(WIN_STUDY);
    else if (difficulty_i == 2'd1) win_sel = 8'(WIN_NORMAL);
    else if (difficulty_i == 2'd2) win_sel = 8'(WIN_HARD);
  end

  // award tier from the final mistake count, saturating add into the slot
  always_comb begin
    award     = 32'd0;
    if (int'(mist_q) <= T1)      award = 32'(P1);
    else if (int'(mist_q) <= T2) award = 32'(P2);
    else if (int'(mist_q) <= T3) award = 32'(P3);
    else if (int'(mist_q) <= T4) award = 32'(P4);
    score_cur = score_q[acct_q];
    sum       = 33'(score_cur) + 33'(award);
    score_new = (|sum[32:SCORE_W]) ? '1 : sum[SCORE_W-1:0];
  end

  // next-state and judging rules
  always_comb begin
    state_d  = state_q;
    mist_d   = mist_q;
    hits_d   = hits_q;
    w_d      = w_q;
    judged_d = judged_q;
    study_d  = study_q;
    win_d    = win_q;
    acct_d   = acct_q;
    last_d   = last_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d  = RUN;
          mist_d   = '0;
          hits_d   = '0;
          w_d      = '0;
          judged_d = 1'b0;
          study_d  = study_i;
          win_d    = win_sel;
          acct_d   = account_i;
          last_d   = reminder_i;
        end
      end
      RUN: begin
        if (abort_i) begin
          state_d = IDLE;
        end else if (tick) begin
          if (song_end_i) begin
            state_d = study_q ? IDLE : SCORE;
          end else if (reminder_i != last_q) begin
            last_d   = reminder_i;
            w_d      = '0;
            judged_d = 1'b0;
          end else if ((reminder_i == '0) || judged_q) begin
            w_d = w_q;
          end else if (key_i == reminder_i) begin
            if (hits_q != '1) hits_d = hits_q + CNT_W'(1);
            judged_d = 1'b1;
            if (study_q) w_d = '0;
          end else if (w_q == win_q - 8'd1) begin
            if (mist_q != '1) mist_d = mist_q + CNT_W'(1);
            judged_d = 1'b1;
          end else begin
            w_d = w_q + 8'd1;
          end
        end
      end
      SCORE: begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // control and run-state registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      div_q    <= '0;
      mist_q   <= '0;
      hits_q   <= '0;
      w_q      <= '0;
      win_q    <= '0;
      judged_q <= 1'b0;
      study_q  <= 1'b0;
      done_q   <= 1'b0;
      acct_q   <= '0;
      last_q   <= '0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      mist_q   <= mist_d;
      hits_q   <= hits_d;
      w_q      <= w_d;
      win_q    <= win_d;
      judged_q <= judged_d;
      study_q  <= study_d;
      done_q   <= done_d;
      acct_q   <= acct_d;
      last_q   <= last_d;
    end
  end

  // account scores persist across runs; only reset clears them
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < ACCOUNTS; i++) score_q[i] <= '0;
    end else if (state_q == SCORE) begin
      score_q[acct_q] <= score_new;
    end
  end

  assign busy_o     = (state_q != IDLE);
  assign mistakes_o = mist_q;
  assign hits_o     = hits_q;
  assign done_o     = done_q;
  assign score_o    = (state_q == IDLE) ? score_q[account_i] : score_q[acct_q];

endmodule

// File: doc/play_judge.md
# play_judge

Parametrised note-judging and scoring engine for the piano's STUDY and CHALLENGE modes. It generalises the fixed eight-key, eight-account judging in the top level:
- configurable key count, account count, score width and tick rate;
- per-difficulty reaction windows;
- hit counting as well as mistake counting;
- configurable score tiers with saturation;
- an explicit run/score FSM with a one-shot completion pulse.

It sits between the music sequencer (which drives `reminder` and `song_end`) and the display/LED blocks (which consume the counters and score).

## Interface
- `KEYS`, 8, number of piano keys; width of `key` and `reminder`
- `ACCOUNTS`, 8, number of user score slots
- `SCORE_W`, 10, width of each account score, saturating
- `CNT_W`, 8, width of the mistake and hit counters, saturating
- `TICK_DIV`, 524288, clk cycles per judge tick (≥2)
- `WIN_EASY` / `WIN_NORMAL` / `WIN_HARD` / `WIN_STUDY`, 60 / 45 / 30 / 120, reaction window in ticks (1..255)
- `T1`, `T2`, `T3`, `T4`, 10, 20, 30, 40, mistake thresholds (ascending)
- `P1`, `P2`, `P3`, `P4`, 5, 3, 2, 1, points awarded at each tier

Ports:
- `clk`  in  1  system clock
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  one-cycle pulse; begins a judged run
- `study`  in  1  1 = STUDY rules, 0 = CHALLENGE rules; sampled at `start`
- `difficulty`  in  2  0 easy, 1 normal, 2 hard, 3 treated as easy; sampled at `start`
- `account`  in  $clog2(ACCOUNTS)  score slot; sampled at `start`
- `abort`  in  1  ends the run without scoring
- `key`  in  KEYS  pressed keys (one-hot expected)
- `reminder`  in  KEYS  expected note; 0 = rest
- `song_end`  in  1  level; sequencer finished
- `busy`  out  1  high in RUN and SCORE
- `mistakes`  out  CNT_W  mistakes in the current/last run
- `hits`  out  CNT_W  notes hit in the current/last run
- `score`  out  SCORE_W  score of the sampled account
- `done`  out  1  one-cycle pulse when SCORE completes

## Operation
- Tick divider: a free-running counter, cleared by `rst`, produces `tick` on every `TICK_DIV`-th clk. All judging happens on tick cycles only. Counters are held between ticks.
- FSM states:
  - IDLE
    - `start` → RUN.
    - On entry to RUN: clear `mistakes`, `hits`, window counter `w`, `judged`; latch `study`, `difficulty`, `account`; capture `last = reminder`.
  - RUN, on each tick, in priority order:
    - `abort` → IDLE, no scoring.
    - `song_end` → SCORE if CHALLENGE; IDLE if STUDY (STUDY never scores).
    - `reminder != last` → `last <= reminder`, `w <= 0`, `judged <= 0`.
    - `reminder == 0` → no judging.
    - `judged == 1` → no action.
    - `key == reminder` → `hits+1`, `judged <= 1`. In STUDY, also `w <= 0`.
    - `w == WIN-1` → `mistakes+1`, `judged <= 1` (exactly one mistake per note).
    - Otherwise → `w+1`.
  - `abort` while in RUN is also honoured on non-tick cycles.
  - SCORE, one cycle:
    - Award selection: `mistakes ≤ T1` → P1; `≤ T2` → P2; `≤ T3` → P3; `≤ T4` → P4; else 0.
    - `score[acct] <= min(score[acct] + award, 2^SCORE_W - 1)`.
    - Pulse `done`; go to IDLE.
- WIN per run: STUDY → `WIN_STUDY`; else selected by `difficulty`.
- `mistakes` and `hits` saturate at `2^CNT_W - 1` and hold their final values in IDLE until the next `start`.
- Scores persist across runs. Only `rst` clears them, and it clears all slots.
- `score` output = slot of the latched account. In IDLE it follows the live `account` input.
- `start` in RUN or SCORE is ignored. `start` and `abort` together in IDLE: `start` wins, and `abort` is evaluated from the next cycle.

## Timing
- Reset values: state IDLE, `busy` 0, `mistakes` 0, `hits` 0, all scores 0, `done` 0, tick counter 0.
- A `rst` mid-run returns to IDLE on the next edge with no scoring.
- `busy` rises the cycle after `start`.
- The first tick is `TICK_DIV` clks after reset, aligned to the free-running divider, not to `start`.
- A hit is registered on the first tick where `key == reminder`, visible on `hits` the cycle after.
- A mistake is registered on tick number WIN after the note change, counting the change tick as tick 0.
- SCORE lasts exactly 1 clk. `done` and the updated `score` appear together on the cycle after SCORE is entered. `busy` drops in that same cycle.

## Test plan
- **Hit vs. miss.** `TICK_DIV=4`, CHALLENGE easy, reminder `8'h01`. Press `8'h01` at tick 5 → `hits=1`, `mistakes=0`. Next note `8'h02` with no key for 60 ticks → `mistakes=1` exactly, no further increment while the note holds.
- **Score tiers.** Run with 12 mistakes, then `song_end` → `done` pulse, `score[acct]=3`. A second run with 0 mistakes on the same account → 8. A run with 41 mistakes → unchanged.
- **Saturation.** `SCORE_W=3`, account at 6, award 5 → score 7. `CNT_W=2`: 5 missed notes → `mistakes=3`.
- **Study mode.** Hard difficulty ignored, window 120; wrong key for 119 ticks, then correct → `hits=1`, `mistakes=0`. `song_end` → IDLE, no `done`, score unchanged.
- **Abort/reset mid-run.** `abort` at mid-note → IDLE next cycle, no `done`, score unchanged. `rst` mid-run → all outputs 0.
- **Rest and start collisions.** `reminder=0` for 200 ticks → no mistakes. `start` during RUN → counters not cleared.
